filter_sel_ctrl: RTL and testbench

FILTER_SEL_CTRL -- requirements
Module: filter_sel_ctrl

---
 rtl/filter_pkg.sv | 30 +++
 rtl/btn_edge.sv | 25 ++
 rtl/filter_sel_ctrl.sv | 126 ++++++++++++
 tb/tb_filter_sel_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and frame geometry for the filter selection controller.
package filter_pkg;

  localparam int IMG_WIDTH    = 320;
  localparam int IMG_HEIGHT   = 240;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W       = 17;
  localparam int PIX_W        = 16;

  typedef enum logic [1:0] {
    SYNC,
    RUN,
    PEND
  } state_e;

  function automatic logic [3:0] step_next(
    input logic [3:0] t,
    input logic [3:0] last
  );
    return (t == last) ? 4'd0 : t + 4'd1;
  endfunction

  function automatic logic [3:0] step_prev(
    input logic [3:0] t,
    input logic [3:0] last
  );
    return (t == 4'd0) ? last : t - 4'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one synchronized button level.
// Stays disarmed after reset until the button has been seen low.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic req_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      armed_q <= armed_q | ~btn_i;
    end
  end

  assign req_o = armed_q & btn_i & ~prev_q;

endmodule

// File: rtl/filter_sel_ctrl.sv
// Frame-synchronous filter index selector with next/prev buttons.
// Optional auto-advance every AUTO_FRAMES frames: FILTER_AUTO_CYCLE_EN.
module filter_sel_ctrl
  import filter_pkg::*;
#(
  parameter int N_FILTERS    = 11,
  parameter int FRAME_PIXELS = 76800,
  parameter int AUTO_FRAMES  = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              auto_en,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] wAddr_in,
  output logic [3:0]        sel,
  output logic              pending,
  output logic              frame_end
);

  localparam logic [3:0] LAST = 4'(N_FILTERS - 1);

  logic req_next;
  logic req_prev;
  logic bnd;
  logic auto_req;

  state_e     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [3:0] sel_q, sel_d;
  logic       pend_q;
  logic       fend_q;

  btn_edge u_next (
    .clk   (clk),
    .rst_n (reset),
    .btn_i (btn_next),
    .req_o (req_next)
  );

  btn_edge u_prev (
    .clk   (clk),
    .rst_n (reset),
    .btn_i (btn_prev),
    .req_o (req_prev)
  );

  // Out-of-range addresses can never match, so they are ignored.
  assign bnd = we_in &&
    (wAddr_in == ADDR_W'(FRAME_PIXELS - 1));

`ifdef FILTER_AUTO_CYCLE_EN
  localparam int CNT_W = $clog2(AUTO_FRAMES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    auto_req = 1'b0;
    if (!auto_en) begin
      cnt_d = '0;
    end else if (bnd) begin
      if (cnt_q == CNT_W'(AUTO_FRAMES - 1)) begin
        cnt_d    = '0;
        auto_req = ~(req_next | req_prev);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_auto;
  assign unused_auto = auto_en | (AUTO_FRAMES < 1);
  assign auto_req    = 1'b0;
`endif

  always_comb begin
    target_d = target_q;
    unique case (1'b1)
      req_next & ~req_prev:
        target_d = step_next(target_q, LAST);
      req_prev & ~req_next:
        target_d = step_prev(target_q, LAST);
      auto_req & ~req_next & ~req_prev:
        target_d = step_next(target_q, LAST);
      default: ;
    endcase
  end

  // Commit the pre-boundary target so a request on
  // the boundary cycle waits for the next frame.
  always_comb begin
    sel_d   = bnd ? target_q : sel_q;
    state_d = state_q;
    if (state_q != SYNC || bnd) begin
      state_d = (target_d != sel_d) ? PEND : RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SYNC;
      target_q <= 4'd0;
      sel_q    <= 4'd0;
      pend_q   <= 1'b0;
      fend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      pend_q   <= (state_d == PEND);
      fend_q   <= bnd;
    end
  end

  assign sel       = sel_q;
  assign pending   = pend_q;
  assign frame_end = fend_q;

endmodule

// File: tb/tb_filter_sel_ctrl.sv
// Scoreboard bench for filter_sel_ctrl: expected commits are queued
// at each boundary and checked when frame_end pulses.
module tb_filter_sel_ctrl;

  localparam int NF = 11;
  localparam int FP = 76800;
  localparam int AF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic        auto_en = 1'b0;
  logic        we_in = 1'b0;
  logic [16:0] wAddr_in = 17'd0;
  logic [3:0]  sel;
  logic        pending;
  logic        frame_end;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int tgt;
  int cur_sel;
  bit in_sync;
  int acnt;

  always #5 clk = ~clk;

  filter_sel_ctrl #(
    .N_FILTERS    (NF),
    .FRAME_PIXELS (FP),
    .AUTO_FRAMES  (AF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .auto_en   (auto_en),
    .we_in     (we_in),
    .wAddr_in  (wAddr_in),
    .sel       (sel),
    .pending   (pending),
    .frame_end (frame_end)
  );

  function automatic int m_next(int t);
    return (t == NF - 1) ? 0 : t + 1;
  endfunction

  function automatic int m_prev(int t);
    return (t == 0) ? NF - 1 : t - 1;
  endfunction

  always @(negedge clk) begin
    int e;
    if (frame_end === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_end_unexpected sel=%0d required no pulse",
                 sel);
      end else begin
        e = exp_q.pop_front();
        if (sel !== 4'(e)) begin
          bad++;
          $display("FAIL commit sel=%0d required %0d", sel, e);
        end
      end
    end
  end

  task automatic do_reset(input bit hold_next);
    @(negedge clk);
    reset    = 1'b0;
    btn_next = hold_next;
    btn_prev = 1'b0;
    we_in    = 1'b0;
    wAddr_in = 17'd0;
    tgt = 0; cur_sel = 0; in_sync = 1'b1; acnt = 0;
    repeat (2) @(negedge clk);
    total++;
    if (sel !== 4'd0 || pending !== 1'b0 || frame_end !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs sel=%0d pend=%b fe=%b required 0 0 0",
               sel, pending, frame_end);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press(input bit n, input bit p);
    bit ep;
    @(negedge clk);
    btn_next = n;
    btn_prev = p;
    if (n && !p) tgt = m_next(tgt);
    if (p && !n) tgt = m_prev(tgt);
    @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    ep = !in_sync && (tgt != cur_sel);
    total++;
    if (pending !== ep) begin
      bad++;
      $display("FAIL press_pending n=%b p=%b pend=%b required %b",
               n, p, pending, ep);
    end
  endtask

  task automatic noise();
    @(negedge clk); we_in = 1'b1; wAddr_in = 17'd5;
    @(negedge clk); wAddr_in = 17'(FP);
    @(negedge clk); wAddr_in = 17'h1FFFF;
    @(negedge clk); we_in = 1'b0; wAddr_in = 17'(FP - 1);
    @(negedge clk); wAddr_in = 17'd0;
  endtask

  task automatic boundary(input bit n);
    bit ep;
    @(negedge clk);
    we_in    = 1'b1;
    wAddr_in = 17'(FP - 1);
    if (n) btn_next = 1'b1;
    exp_q.push_back(tgt);
    cur_sel = tgt;
    in_sync = 1'b0;
`ifdef FILTER_AUTO_CYCLE_EN
    if (auto_en) begin
      if (acnt == AF - 1) begin
        acnt = 0;
        if (!n) tgt = m_next(tgt);
      end else begin
        acnt++;
      end
    end
`endif
    if (n) tgt = m_next(tgt);
    @(negedge clk);
    we_in    = 1'b0;
    wAddr_in = 17'd0;
    if (n) btn_next = 1'b0;
    ep = (tgt != cur_sel);
    total++;
    if (pending !== ep) begin
      bad++;
      $display("FAIL boundary_pending pend=%b required %b", pending, ep);
    end
    @(negedge clk);
    total++;
    if (frame_end !== 1'b0) begin
      bad++;
      $display("FAIL frame_end_width fe=%b required 0", frame_end);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
  endtask

  task automatic test_first_commit();
    noise();
    press(1'b1, 1'b0);
    noise();
    total++;
    if (sel !== 4'd0) begin
      bad++;
      $display("FAIL sel_before_boundary sel=%0d required 0", sel);
    end
    boundary(1'b0);
  endtask

  task automatic test_wrap();
    repeat (9) press(1'b1, 1'b0);
    boundary(1'b0);
    press(1'b1, 1'b0);
    boundary(1'b0);
    press(1'b0, 1'b1);
    boundary(1'b0);
  endtask

  task automatic test_both();
    press(1'b1, 1'b1);
    boundary(1'b0);
  endtask

  task automatic test_cancel();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    boundary(1'b0);
  endtask

  task automatic test_boundary_req();
    boundary(1'b1);
    noise();
    boundary(1'b0);
  endtask

  task automatic test_reset_mid();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    do_reset(1'b0);
    noise();
    boundary(1'b0);
  endtask

  task automatic test_reset_held();
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    boundary(1'b0);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (2) @(negedge clk);
    press(1'b1, 1'b0);
    boundary(1'b0);
  endtask

  task automatic test_auto();
    int es;
    do_reset(1'b0);
    auto_en = 1'b1;
    repeat (6) boundary(1'b0);
    auto_en = 1'b0;
`ifdef FILTER_AUTO_CYCLE_EN
    es = 2;
`else
    es = 0;
`endif
    total++;
    if (sel !== 4'(es)) begin
      bad++;
      $display("FAIL auto_cycle sel=%0d required %0d", sel, es);
    end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_wrap();
    test_both();
    test_cancel();
    test_boundary_req();
    test_reset_mid();
    test_reset_held();
    test_auto();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_commits left=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
